uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
// - UART 8N1 transmitter with a small byte FIFO. It is the transmit counterpart of the core's UART receive path.
// - Core-side logic pushes bytes with a valid/ready handshake; the block serialises them onto the tx pin (uo_out[0]).
// - The bench samples tx and decodes the frames as a UART receiver.
// PARAMETERS
// - CLKS_PER_BIT  434  clk cycles per bit time (50 MHz / 115200); legal range 2..65535
// - FIFO_DEPTH    4    byte entries; power of two, 2..16
// PORTS
// - clk         in   1                   system clock; all logic on the rising edge
// - rst_n       in   1                   asynchronous active-low reset; one clock, no other clock domains
// - tx_data     in   8                   byte to send
// - tx_valid    in   1                   tx_data is valid this cycle
// - tx_ready    out  1                   FIFO can accept a byte (= !full)
// - tx          out  1                   serial line; idle high
// - busy        out  1                   frame in progress OR FIFO non-empty
// - fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted
// BEHAVIOUR
// - Reset (async assert, sync release): tx=1, tx_ready=1, busy=0, fifo_count=0, FSM=IDLE; all counters and pointers cleared.
//   - Reset mid-frame aborts the frame: tx returns high immediately and the queued bytes are discarded.
// - Push: a byte is written when tx_valid && tx_ready at a clk edge.
//   - tx_ready is combinational from full only; it does not depend on tx_valid.
//   - When the FIFO is full, tx_ready=0 and the byte is not written; there is no push-through even if a pop occurs that cycle.
// - Pop: happens when the FSM takes the next byte (see IDLE and STOP).
//   - Push and pop in the same cycle is legal when not full: count is unchanged and the pointers wrap modulo FIFO_DEPTH.
// - FSM states: IDLE, START, DATA, STOP.
//   - IDLE: tx=1. If the FIFO is non-empty, pop into shift_reg and go to START.
//   - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
//   - DATA: tx=shift_reg[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then shift right and bit_idx++. After bit 7, go to STOP.
//   - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap between frames); otherwise go to IDLE.
// - Baud counter: counts 0..CLKS_PER_BIT-1.
//   - It resets to 0 on every state entry.
//   - bit_done is asserted when count == CLKS_PER_BIT-1.
//   - The counter width is $clog2(CLKS_PER_BIT); the compare must not overflow.
// - Frame timing: one frame is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
// - Latency: a byte pushed into an empty FIFO while IDLE is popped on the next edge, and tx falls on the edge after that (2 cycles after the handshake edge).
// - tx is registered (glitch-free); it is driven from the FSM/shift register flops, not decoded combinationally.
// - busy=0 only when FSM=IDLE and fifo_count=0.
// STRUCTURE
// - Shared package uart_pkg:
//   - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   - UART_DATA_BITS=8
//   - default CLKS_PER_BIT constant, shared with the receiver so both ends agree on the baud rate
// - One sub-module, uart_tx_fifo:
//   - synchronous FIFO, parameter FIFO_DEPTH, width 8
//   - ports push/pop/din/dout/full/empty/count
//   - pointers one bit wider than the index, for full/empty detection
// - The top holds the FSM, baud counter, bit index and shift register.
// - Top-level integration maps tx to uo_out[0].
// TESTING (bench runs CLKS_PER_BIT=4, FIFO_DEPTH=4)
// - Reset:
//   - hold rst_n=0 -> tx=1, tx_ready=1, busy=0, fifo_count=0
//   - release rst_n with no push -> tx stays 1 for 100 cycles
// - Single byte 0xA5:
//   - tx falls 2 cycles after the handshake
//   - sampling at mid-bit gives 0, 1,0,1,0,0,1,0,1, then stop bit 1
//   - frame is 40 cycles; busy falls when the frame ends
// - Back-to-back 0x00, 0xFF, 0x55 pushed on consecutive cycles:
//   - three contiguous 40-cycle frames with no extra idle cycles
//   - the decoder recovers the same three bytes in order
// - Full FIFO: push 6 bytes with tx_valid held high
//   - 1 byte is in shift, 4 are queued
//   - tx_ready=0 while fifo_count=4 and the 6th byte waits
//   - 6th byte is accepted when the first pop occurs; all 6 decode correctly
// - Simultaneous push/pop:
//   - push on the exact cycle the STOP->START pop happens -> fifo_count unchanged, no byte lost or duplicated
//   - pointer wrap is exercised with 12 bytes
// - Reset mid-frame: assert rst_n in DATA bit 3
//   - tx=1 immediately, fifo_count=0
//   - after release, a new byte 0x3C is sent cleanly

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame geometry and the default baud
// divider. The receiver imports the same package so both ends agree on timing.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  // 50 MHz system clock / 115200 baud
  localparam int UART_CLKS_PER_BIT_DEFAULT = 434;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Line level that a given FSM state puts on the wire.
  function automatic logic tx_level(input logic [1:0] state, input logic data_lsb);
    logic level;
    level = 1'b1;
    case (state)
      ST_START: level = 1'b0;
      ST_DATA:  level = data_lsb;
      default:  level = 1'b1;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_W-1:0]           din,
  output logic [DATA_W-1:0]           dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              do_push, do_pop;

  // A full FIFO refuses the write even if a pop happens the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; indices wrap naturally modulo FIFO_DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers, cleared on reset so queued bytes are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART 8N1 transmitter: byte FIFO in front of a framing FSM.
// In the chip integration, tx drives uo_out[0].
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit time
// DATA  | eight data bits, LSB first, one bit time each
// STOP  | stop bit (high); pops the next byte at its end if available
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   BAUD_ONE  = CW'(1);
  localparam int              BW        = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(UART_DATA_BITS - 1);
  localparam logic [BW-1:0]   BIT_ONE   = BW'(1);

  logic [1:0]                  state_q, state_d;
  logic [CW-1:0]               baud_q, baud_d;
  logic [BW-1:0]               bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic                        tx_q, tx_d;
  logic                        bit_done;

  logic                        fifo_push, fifo_pop;
  logic [7:0]                  fifo_dout;
  logic                        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

  assign fifo_push = tx_valid && !fifo_full;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Same-width compare against CLKS_PER_BIT-1, so no overflow at the top of range.
  assign bit_done = (baud_q == BAUD_LAST);

  // Framing FSM, baud counter, bit index and shift register next-state.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (bit_idx_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_ONE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          baud_d = '0;
          // Chain directly into the next frame to keep the line contiguous.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // Line level follows the current state through a flop, so tx is glitch-free
  // and trails the FSM by one cycle uniformly across the frame.
  always_comb begin
    tx_d = tx_level(state_q, shift_q[0]);
  end

  // FSM and datapath registers; reset aborts any frame and forces the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign tx_ready   = !fifo_full;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign fifo_count = fifo_cnt;

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] sb[$];
  int         starts[$];
  int         last_hs = 0;
  int         cnt_at_accept = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART receiver model: samples at mid-bit on the falling clock edge.
  logic       dec_active = 1'b0;
  logic       prev_tx = 1'b1;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = 8'h00;
  logic [7:0] exp_byte;

  always @(negedge clk) begin
    if (!rst_n) begin
      dec_active = 1'b0;
      prev_tx    = 1'b1;
    end else if (!dec_active) begin
      if (prev_tx && !tx) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
        starts.push_back(cyc);
      end
      prev_tx = tx;
    end else begin
      dec_cnt++;
      if (dec_cnt == CPB/2) begin
        check("start_bit", tx, 1'b0);
      end else if (dec_cnt < CPB/2 + 9*CPB) begin
        if ((dec_cnt - CPB/2) % CPB == 0) dec_byte = {tx, dec_byte[7:1]};
      end else if (dec_cnt == CPB/2 + 9*CPB) begin
        check("stop_bit", tx, 1'b1);
        check("frame_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          exp_byte = sb.pop_front();
          check("rx_byte", dec_byte, exp_byte);
        end
        dec_active = 1'b0;
        prev_tx    = tx;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic push_byte(input logic [7:0] b, output int waited);
    tx_data  = b;
    tx_valid = 1'b1;
    waited   = 0;
    while (tx_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("push_no_timeout", tx_ready, 1'b1);
    if (tx_ready === 1'b1) begin
      sb.push_back(b);
      last_hs       = cyc + 1;
      cnt_at_accept = int'(fifo_count);
    end
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag, input int max);
    int n;
    tx_valid = 1'b0;
    n = 0;
    while (!(sb.size() == 0 && busy === 1'b0 && !dec_active) && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < max, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_start(input int n0, output int s);
    int n;
    n = 0;
    while (starts.size() <= n0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", starts.size() > n0, 1'b1);
    s = (starts.size() > n0) ? starts[n0] : -1000;
  endtask

  int w, s, n0, hs, cnt_low;
  logic [7:0] bytes6 [6];
  logic [7:0] bytes12 [12];

  initial begin
    bytes6  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h81, 8'hE7};
    bytes12 = '{8'hC0, 8'hC1, 8'h3A, 8'h5C, 8'h01, 8'h80,
                8'h7E, 8'hF0, 8'h0F, 8'h96, 8'h69, 8'hDB};

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_tx_ready", tx_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_fifo_count", fifo_count, 3'd0);
    rst_n = 1'b1;
    cnt_low = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) cnt_low++;
    end
    check("idle_tx_high", cnt_low, 0);
    check("idle_busy", busy, 1'b0);

    // Single byte 0xA5: latency, busy envelope
    n0 = starts.size();
    push_byte(8'hA5, w);
    hs = last_hs;
    tx_valid = 1'b0;
    check("busy_after_push", busy, 1'b1);
    wait_start(n0, s);
    check("a5_latency", s - hs, 2);
    while (cyc < s + 37) @(negedge clk);
    check("a5_busy_in_frame", busy, 1'b1);
    while (cyc < s + 41) @(negedge clk);
    check("a5_busy_after_frame", busy, 1'b0);
    check("a5_line_idle", tx, 1'b1);
    wait_drain("a5_drain", 200);

    // Back-to-back frames
    n0 = starts.size();
    push_byte(8'h00, w);
    push_byte(8'hFF, w);
    push_byte(8'h55, w);
    wait_drain("b2b_drain", 400);
    check("b2b_frames", starts.size() - n0, 3);
    if (starts.size() >= n0 + 3) begin
      check("b2b_gap1", starts[n0+1] - starts[n0], 10*CPB);
      check("b2b_gap2", starts[n0+2] - starts[n0+1], 10*CPB);
    end

    // Full FIFO with tx_valid held high
    for (int i = 0; i < 5; i++) push_byte(bytes6[i], w);
    check("full_count", fifo_count, 3'd4);
    check("full_not_ready", tx_ready, 1'b0);
    check("full_busy", busy, 1'b1);
    push_byte(bytes6[5], w);
    check("full_blocked", w > 30, 1'b1);
    check("full_count_at_accept", cnt_at_accept, 3);
    wait_drain("full_drain", 600);

    // Push coinciding with the STOP->START pop, then wrap the pointers
    n0 = starts.size();
    push_byte(bytes12[0], w);
    hs = last_hs;
    push_byte(bytes12[1], w);
    tx_valid = 1'b0;
    while (cyc < hs + 40) @(negedge clk);
    check("pp_count_before", fifo_count, 3'd1);
    push_byte(bytes12[2], w);
    check("pp_hs_cycle", last_hs - hs, 41);
    check("pp_count_after", fifo_count, 3'd1);
    for (int i = 3; i < 12; i++) push_byte(bytes12[i], w);
    wait_drain("wrap_drain", 1200);
    check("wrap_frames", starts.size() - n0, 12);

    // Reset during DATA bit 3
    n0 = starts.size();
    push_byte(8'h96, w);
    push_byte(8'h11, w);
    push_byte(8'h22, w);
    tx_valid = 1'b0;
    wait_start(n0, s);
    while (cyc < s + 17) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_count", fifo_count, 3'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", tx_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n0 = starts.size();
    push_byte(8'h3C, w);
    wait_drain("post_rst_drain", 200);
    check("post_rst_frames", starts.size() - n0, 1);
    check("sb_empty_end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
